// File: rtl/bench_ctrl_pkg.sv
// bench_ctrl_pkg: shared states, polynomials and LFSR step for the benchmark run controller
package bench_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RST_DUT, RUN, DRAIN, DONE} state_t;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h0000_1021;
  localparam logic [31:0] LFSR_ZERO_SUB = 32'h0000_0001;
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction
endpackage

// File: rtl/bench_misr.sv
// bench_misr: multiple-input signature register compacting the DUT output stream
module bench_misr
  import bench_ctrl_pkg::*;
#(
  parameter int SIG_W = 16,
  parameter int OUT_W = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [SIG_W-1:0] sig
);
  always_ff @(posedge clk)
    if (clr) sig <= '0;
    else if (en) sig <= (sig << 1) ^ (sig[SIG_W-1] ? SIG_W'(MISR_POLY) : '0) ^ SIG_W'(din);
endmodule

// File: rtl/bench_run_ctrl.sv
// bench_run_ctrl: sequences one benchmark run (DUT reset, LFSR vectors, MISR signature)
module bench_run_ctrl
  import bench_ctrl_pkg::*;
#(
  parameter int IN_W    = 18,
  parameter int OUT_W   = 1,
  parameter int SIG_W   = 16,
  parameter int CNT_W   = 16,
  parameter int RST_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_vectors,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             dut_rst_n,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out
);
  localparam int RW = $clog2(RST_CYC + 1);
  state_t           state;
  logic [31:0]      lfsr;
  logic [CNT_W-1:0] n;
  logic [CNT_W-1:0] vcnt;
  logic [RW-1:0]    rcnt;
  logic             in_run;
  logic             cancel;
  logic             misr_clr;
  assign in_run = state inside {RST_DUT, RUN, DRAIN};
  assign cancel = in_run && abort;
  assign misr_clr = reset || (state == IDLE && start) || cancel;
  // each RUN edge closes a cycle in which a vector was on dut_in, so its response is sampled there
  bench_misr #(.SIG_W(SIG_W), .OUT_W(OUT_W)) u_misr (
    .clk(clk),
    .clr(misr_clr),
    .en(state == RUN),
    .din(dut_out),
    .sig(signature)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_in    <= '0;
      dut_rst_n <= 1'b0;
      lfsr      <= LFSR_ZERO_SUB;
      n         <= '0;
      vcnt      <= '0;
      rcnt      <= '0;
    end else if (cancel) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      dut_in    <= '0;
      dut_rst_n <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dut_rst_n <= !start;
          if (start) begin
            state <= RST_DUT;
            busy  <= 1'b1;
            lfsr  <= (seed == '0) ? LFSR_ZERO_SUB : seed;
            n     <= num_vectors;
            vcnt  <= '0;
            rcnt  <= '0;
          end
        end
        RST_DUT:
          if (rcnt == RW'(RST_CYC - 1)) begin
            dut_rst_n <= 1'b1;
            if (n == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state  <= RUN;
              dut_in <= lfsr[IN_W-1:0];
              lfsr   <= lfsr_step(lfsr);
              vcnt   <= CNT_W'(1);
            end
          end else rcnt <= rcnt + RW'(1);
        RUN:
          if (vcnt == n) begin
            state  <= DRAIN;
            dut_in <= '0;
          end else begin
            dut_in <= lfsr[IN_W-1:0];
            lfsr   <= lfsr_step(lfsr);
            vcnt   <= vcnt + CNT_W'(1);
          end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/bench_run_ctrl.md
# bench_run_ctrl

Run controller for the generic sequential benchmark circuits: sequences one test run of a benchmark DUT. It holds the DUT in reset, applies a programmable number of pseudo-random input vectors, compacts the DUT output into a signature, and reports completion. It sits between the test host and a single benchmark instance, so golden and trojan-inserted variants can be compared by signature.

## Interface
- `IN_W`, 18, DUT input width (1..32)
- `OUT_W`, 1, DUT output width (1..`SIG_W`)
- `SIG_W`, 16, signature width
- `CNT_W`, 16, vector-count width
- `RST_CYC`, 2, cycles the DUT reset is held per run (≥1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a run; sampled only in IDLE
- `abort`  in  1  cancel a run in progress
- `seed`  in  32  LFSR seed, captured on start
- `num_vectors`  in  `CNT_W`  vectors to apply, captured on start
- `busy`  out  1  high from the cycle after start through DRAIN
- `done`  out  1  one-cycle pulse; `signature` valid
- `signature`  out  `SIG_W`  MISR contents
- `dut_rst_n`  out  1  active-low reset to DUT
- `dut_in`  out  `IN_W`  DUT input vector
- `dut_out`  in  `OUT_W`  DUT output

## Operation
- FSM states are IDLE, RST_DUT, RUN, DRAIN, DONE.
- IDLE → RST_DUT on `start`:
  - load the LFSR with `seed`, or with 32'h1 if `seed` is 0;
  - latch `num_vectors`;
  - clear the signature and the counters.
- RST_DUT: `dut_rst_n`=0 for exactly `RST_CYC` cycles. It then goes to RUN, or directly to DONE if the latched count is 0.
- RUN: one vector per cycle, for exactly N cycles.
  - `dut_in` = lfsr[`IN_W`-1:0].
  - The LFSR advances every RUN cycle as a Galois right shift: next = (lfsr>>1) ^ (lfsr[0] ? 32'h80200003 : 0).
  - After the last vector, go to DRAIN.
- DRAIN: one cycle, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- MISR:
  - Samples `dut_out` on every edge where a vector was applied in the previous cycle, i.e. RUN cycles 2..N plus DRAIN, for N samples in total.
  - Update: sig = (sig<<1) ^ (sig[`SIG_W`-1] ? 16'h1021-style poly `MISR_POLY` : 0) ^ zero-extended `dut_out`.
  - Held constant outside sampling edges.
- `dut_in` = 0 outside RUN. `dut_rst_n`=1 in IDLE, RUN, DRAIN and DONE.
- `abort` in RST_DUT, RUN or DRAIN:
  - next state is IDLE;
  - no `done` pulse;
  - signature cleared to 0.
  - `abort` in IDLE or DONE is ignored.
- Simultaneous `start`+`abort` in IDLE: `start` wins.
- `start` while busy is ignored. Inputs captured on start are unaffected by later changes.
- `reset`: state IDLE, `busy`=0, `done`=0, `signature`=0, `dut_in`=0, `dut_rst_n`=0 while `reset` is high. This holds regardless of state, including mid-run.

## Timing
- `start` sampled at edge 0:
  - RST_DUT occupies cycles 1..`RST_CYC`;
  - RUN occupies the next N cycles;
  - DRAIN takes 1 cycle;
  - `done` is in cycle `RST_CYC`+N+2.
- With N=0, `done` is in cycle `RST_CYC`+1.
- `busy` rises in cycle 1 and falls in the DONE cycle.
- `signature` is stable from DONE until the next accepted start.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Package `bench_ctrl_pkg`:
  - state enum;
  - `LFSR_POLY` (32'h80200003);
  - `MISR_POLY` (`SIG_W`'h1021);
  - LFSR zero-seed substitute (32'h1).
- Sub-module `bench_misr`: parameterised by `SIG_W`/`OUT_W`, with clear, enable, data in and signature out. The FSM, LFSR and counters live in `bench_run_ctrl`.

## Test plan
- `RST_CYC`=2, N=4, `start` at cycle 0:
  - `dut_rst_n` low in cycles 1–2;
  - RUN in cycles 3–6;
  - `done` exactly in cycle 8;
  - `busy` high in cycles 1–7.
- `seed`=32'h1, N=2:
  - first `dut_in`=18'h00001;
  - second `dut_in`=18'h00003;
  - `dut_in`=0 before and after RUN.
- `dut_out` tied to 1, N=3 → `signature`=16'h0007. `dut_out` tied to 0, any N → 16'h0000.
- N=0 → `done` in cycle `RST_CYC`+1, `signature`=0, `dut_in` never nonzero.
- `abort` in the 2nd RUN cycle:
  - IDLE next cycle, `busy`=0, no `done`, `signature`=0;
  - a subsequent `start` runs to completion normally.
- `reset` pulsed mid-RUN → all outputs at reset values, `dut_rst_n`=0 during reset. `start` during a run is ignored, and the captured N is unchanged.
